// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Latency: XLEN+1 cycles from accepted start to done_o; divide-special cases (and MUL* with MDU_FAST_MUL_EN) take 1.
// Backpressure: busy_o is high from acceptance through DONE; start_i is ignored while busy_o=1.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wren_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opb;
  logic            neg_q;
  logic            neg_r;

  function automatic logic [XLEN-1:0] mul_result(input logic [1:0] f,
                                                 input logic [2*XLEN-1:0] p,
                                                 input logic neg);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, special, fast_mul;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Decode of the request as presented in IDLE; MULHSU treats only rs1 as signed.
  always_comb begin
    is_div   = funct3_i[2];
    a_sgn    = is_div ? ~funct3_i[0] : ~(funct3_i[1] & funct3_i[0]);
    b_sgn    = is_div ? ~funct3_i[0] : ~funct3_i[1];
    a_neg    = a_sgn & rs1_data_i[XLEN-1];
    b_neg    = b_sgn & rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = is_div && (rs2_data_i == '0);
    div_ovf  = is_div && !funct3_i[0] && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3_i[1] ? rs1_data_i : '1;
    else          special_res = funct3_i[1] ? '0 : rs1_data_i;
`ifdef MDU_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_mul  = !is_div;
    fast_res  = mul_result(funct3_i[1:0], fast_prod, a_neg ^ b_neg);
`else
    fast_mul  = 1'b0;
    fast_res  = '0;
`endif
  end

  logic [XLEN:0]   add_sum, shifted, diff;
  logic [XLEN-1:0] hi_nx, lo_nx, calc_res;

  // One iteration: acc_lo holds the multiplier (mul) or the dividend/quotient (div).
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    if (op[2]) begin
      if (!diff[XLEN]) begin
        hi_nx = diff[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = shifted[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = add_sum[XLEN:1];
      lo_nx = {add_sum[0], acc_lo[XLEN-1:1]};
    end
    if (op[2]) calc_res = op[1] ? (neg_r ? -hi_nx : hi_nx) : (neg_q ? -lo_nx : lo_nx);
    else       calc_res = mul_result(op[1:0], {hi_nx, lo_nx}, neg_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      rd_wren_o <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rd_wren_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op        <= funct3_i;
            rd_addr_o <= rd_addr_i;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            cnt       <= CW'(XLEN-1);
            acc_hi    <= '0;
            acc_lo    <= is_div ? a_mag : b_mag;
            opb       <= is_div ? b_mag : a_mag;
            busy_o    <= 1'b1;
            if (special || fast_mul) begin
              state     <= DONE;
              done_o    <= 1'b1;
              rd_wren_o <= (rd_addr_i != 5'd0);
              rd_data_o <= special ? special_res : fast_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            done_o    <= 1'b1;
            rd_wren_o <= (rd_addr_o != 5'd0);
            rd_data_o <= calc_res;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: latency, RV32M results, special cases, reset abort, back-to-back.
module tb_mdu_iterative;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  f;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, done, wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .funct3_i(f),
    .rs1_data_i(a), .rs2_data_i(b), .rd_addr_i(rd),
    .busy_o(busy), .done_o(done), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data), .rd_wren_o(wren_o)
  );

  always #5 clk = ~clk;

  // Issues one op, scrambles inputs after acceptance, reports what came back and when.
  task automatic run_op(input logic [2:0] fn, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [4:0] rd_in, output logic [31:0] data, output logic [4:0] addr,
                        output logic wr, output int cyc, output logic clean);
    @(negedge clk);
    start = 1'b1; f = fn; a = op_a; b = op_b; rd = rd_in;
    @(posedge clk); #1;
    start = 1'b0; f = ~fn; a = ~op_a; b = op_b + 32'd1; rd = ~rd_in;
    cyc = -1; data = '0; addr = '0; wr = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        cyc = n; data = rd_data; addr = rd_addr_o; wr = wren_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clean = !done && !busy;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wren_o !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl busy=%b done=%b wren=%b want 000", busy, done, wren_o); end
    checks++; if (rd_data !== 32'h0 || rd_addr_o !== 5'h0) begin errors++;
      $display("FAIL reset_data data=%h addr=%0d want 0/0", rd_data, rd_addr_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] d; logic [4:0] ad; logic w, ok; int c;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_data got %h want FFFFFFEB", d); end
    checks++; if (c !== MUL_CYC) begin errors++; $display("FAIL mul_cycle got %0d want %0d", c, MUL_CYC); end
    checks++; if (ad !== 5'd5) begin errors++; $display("FAIL mul_addr got %0d want 5", ad); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL mul_wren got %b want 1", w); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mul_one_pulse got %b want 1", ok); end
  endtask

  task automatic test_mul_high();
    logic [31:0] d; logic [4:0] ad; logic w, ok; int c;
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, d, ad, w, c, ok);
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL mulh_data got %h want 40000000", d); end
    checks++; if (c !== MUL_CYC) begin errors++; $display("FAIL mulh_cycle got %0d want %0d", c, MUL_CYC); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_data got %h want FFFFFFFE", d); end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_data got %h want FFFFFFFF", d); end
  endtask

  task automatic test_div();
    logic [31:0] d; logic [4:0] ad; logic w, ok; int c;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_data got %h want FFFFFFFD", d); end
    checks++; if (c !== 33) begin errors++; $display("FAIL div_cycle got %0d want 33", c); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd5, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_data got %h want FFFFFFFF", d); end
    run_op(3'b101, 32'hFFFFFFFF, 32'h10, 5'd5, d, ad, w, c, ok);
    checks++; if (d !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu_data got %h want 0FFFFFFF", d); end
    checks++; if (c !== 33) begin errors++; $display("FAIL divu_cycle got %0d want 33", c); end
  endtask

  task automatic test_special();
    logic [31:0] d; logic [4:0] ad; logic w, ok; int c;
    run_op(3'b100, 32'd5, 32'd0, 5'd8, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_data got %h want FFFFFFFF", d); end
    checks++; if (c !== 1) begin errors++; $display("FAIL div0_cycle got %0d want 1", c); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div0_one_pulse got %b want 1", ok); end
    run_op(3'b111, 32'd5, 32'd0, 5'd8, d, ad, w, c, ok);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL remu0_data got %h want 00000005", d); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, d, ad, w, c, ok);
    checks++; if (d !== 32'h80000000) begin errors++; $display("FAIL divovf_data got %h want 80000000", d); end
    checks++; if (c !== 1) begin errors++; $display("FAIL divovf_cycle got %0d want 1", c); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd8, d, ad, w, c, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL removf_data got %h want 00000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [4:0] ad; logic w, ok, seen; int c;
    @(negedge clk);
    start = 1'b1; f = 3'b100; a = 32'd100; b = 32'd7; rd = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wren_o !== 1'b0) begin errors++;
      $display("FAIL rstmid_ctrl busy=%b done=%b wren=%b want 000", busy, done, wren_o); end
    checks++; if (rd_data !== 32'h0 || rd_addr_o !== 5'h0) begin errors++;
      $display("FAIL rstmid_data data=%h addr=%0d want 0/0", rd_data, rd_addr_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b want 0", seen); end
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, d, ad, w, c, ok);
    checks++; if (d !== 32'hFFFFFFFD || c !== 33) begin errors++;
      $display("FAIL rstmid_restart data=%h cyc=%0d want FFFFFFFD/33", d, c); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] gd[4]; logic [4:0] ga[4]; logic gw[4]; int gc[4]; int nd;
    logic [31:0] ed[3]; logic [4:0] ea[3]; logic ew[3]; int ec[3];
    ed = '{32'hFFFFFFFF, 32'h0FFFFFFF, 32'h0};
    ea = '{5'd3, 5'd0, 5'd7};
    ew = '{1'b1, 1'b0, 1'b1};
    ec = '{1, 35, 37};
    nd = 0;
    for (int e = 0; e <= 40; e++) begin
      @(negedge clk);
      start = (e <= 36);
      case (e)
        0:       begin f = 3'b100; a = 32'd5;        b = 32'd0;        rd = 5'd3; end
        2:       begin f = 3'b101; a = 32'hFFFFFFFF; b = 32'h10;       rd = 5'd0; end
        36:      begin f = 3'b110; a = 32'h80000000; b = 32'hFFFFFFFF; rd = 5'd7; end
        default: begin f = 3'b111; a = 32'h1234;     b = 32'd0;        rd = 5'd9; end
      endcase
      @(posedge clk); #1;
      if (done) begin
        if (nd < 4) begin gd[nd] = rd_data; ga[nd] = rd_addr_o; gw[nd] = wren_o; gc[nd] = e + 1; end
        nd++;
      end
    end
    start = 1'b0;
    checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nd); end
    for (int i = 0; i < 3; i++) begin
      if (i < nd) begin
        checks++; if (gd[i] !== ed[i] || ga[i] !== ea[i] || gw[i] !== ew[i] || gc[i] !== ec[i]) begin
          errors++;
          $display("FAIL b2b_op%0d got data=%h addr=%0d wren=%b cyc=%0d want %h/%0d/%b/%0d",
                   i, gd[i], ga[i], gw[i], gc[i], ed[i], ea[i], ew[i], ec[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; f = '0; a = '0; b = '0; rd = '0;
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
